// File: rtl/axi_packet_fifo.sv
// Store-and-forward AXI4-Stream packet FIFO.
// A packet is released downstream only after its tlast beat is stored, so the
// width converter that follows always sees each packet as one uninterrupted burst.
// A packet larger than the buffer falls back to cut-through so the block cannot
// deadlock. Store-and-forward resumes after that packet's tlast beat is read.
module axi_packet_fifo #(
  parameter int DATA_WIDTH = 512,
  parameter int DEPTH      = 64
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [DATA_WIDTH-1:0]        in_tdata,
  input  logic [DATA_WIDTH/8-1:0]      in_tkeep,
  input  logic                         in_tlast,
  input  logic                         in_tvalid,
  output logic                         in_tready,
  output logic [DATA_WIDTH-1:0]        out_tdata,
  output logic [DATA_WIDTH/8-1:0]      out_tkeep,
  output logic                         out_tlast,
  output logic                         out_tvalid,
  input  logic                         out_tready,
  output logic [$clog2(DEPTH+1)-1:0]   fill_level,
  output logic [$clog2(DEPTH+1)-1:0]   pkt_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int KW = DATA_WIDTH / 8;
  localparam int EW = DATA_WIDTH + KW + 1;

  if (!(DATA_WIDTH == 256 || DATA_WIDTH == 512)) begin : g_bad_width
    $error("axi_packet_fifo: DATA_WIDTH must be 256 or 512");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("axi_packet_fifo: DEPTH must be a power of two >= 2");
  end

  // Entry layout: {tlast, tkeep, tdata}
  logic [EW-1:0] mem [DEPTH];

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] pkt_cnt;
  logic          ct_q;

  logic wr_en;
  logic rd_en;
  logic wr_last;
  logic rd_last;
  logic full;
  logic empty;
  logic ct_now;

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign ct_now    = full && (pkt_cnt == '0);

  assign in_tready = !full;
  assign wr_en     = in_tvalid && in_tready;
  assign wr_last   = wr_en && in_tlast;

  // Outputs present the head entry combinationally; no same-cycle bypass when full.
  assign {out_tlast, out_tkeep, out_tdata} = mem[rd_ptr];
  assign out_tvalid = !empty && ((pkt_cnt != '0) || ct_q || ct_now);
  assign rd_en      = out_tvalid && out_tready;
  assign rd_last    = rd_en && out_tlast;

  assign fill_level = count;
  assign pkt_count  = pkt_cnt;

  // Storage array write; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= {in_tlast, in_tkeep, in_tdata};
    end
  end

  // Circular pointers wrap naturally modulo DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
    end
  end

  // Beat occupancy: simultaneous write and read leave it unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else begin
      case ({wr_en, rd_en})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Complete packets stored = tlast beats written but not yet read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_cnt <= '0;
    end else begin
      case ({wr_last, rd_last})
        2'b10:   pkt_cnt <= pkt_cnt + CW'(1);
        2'b01:   pkt_cnt <= pkt_cnt - CW'(1);
        default: pkt_cnt <= pkt_cnt;
      endcase
    end
  end

  // Cut-through latch: held from the first full-with-no-packet cycle until the
  // oversized packet's tlast is read. The clear wins over a same-cycle set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ct_q <= 1'b0;
    end else if (rd_last) begin
      ct_q <= 1'b0;
    end else if (ct_now) begin
      ct_q <= 1'b1;
    end
  end

endmodule
